// File: rtl/pc_unit_if.sv
// pc_unit_if: fetch-side control bundle for the program-counter unit.
//
// Parameters:
//   WIDTH      address / immediate width in bits.
// Signals:
//   immediate  branch offset (two's complement) or absolute jump target
//   pc_src     next-PC select: 00 increment, 01 relative, 10 absolute, 11 return
//   call       push PC+1 onto the return-address stack this cycle
//   stall      hold PC and all stack state
//   pc         current instruction address
//   ras_empty  return-address stack holds no entries
//   ras_full   return-address stack holds RAS_DEPTH entries
//   ras_err    sticky overflow / underflow flag
// Modports:
//   master     fetch controller (drives select/immediate, observes PC and flags)
//   slave      the pc_unit itself
interface pc_unit_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] immediate;
  logic [1:0]       pc_src;
  logic             call;
  logic             stall;
  logic [WIDTH-1:0] pc;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_err;

  modport master (
    output immediate,
    output pc_src,
    output call,
    output stall,
    input  pc,
    input  ras_empty,
    input  ras_full,
    input  ras_err
  );

  modport slave (
    input  immediate,
    input  pc_src,
    input  call,
    input  stall,
    output pc,
    output ras_empty,
    output ras_full,
    output ras_err
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: parametrised program counter with optional return-address stack.
//
// Each unstalled rising edge the PC advances to one of: PC+1, PC+immediate
// (signed, modulo 2^WIDTH), immediate (absolute), or the top of the RAS.
// All arithmetic wraps silently.
//
// Build option:
//   PC_RAS_EN  when defined, a circular RAS_DEPTH-entry return-address stack is
//              built. When undefined, call is ignored, pc_src=11 increments, and
//              ras_empty/ras_full/ras_err are constant 1/0/0.
//
// Parameters:
//   WIDTH       address / immediate width (>= 4)
//   RAS_DEPTH   return-address stack entries (power of two, >= 2)
//   RESET_ADDR  PC value while reset is asserted
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   bus         pc_unit_if slave modport (select, immediate, call, stall in;
//               pc and RAS status out)
module pc_unit #(
  parameter int unsigned      WIDTH      = 8,
  parameter int unsigned      RAS_DEPTH  = 4,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
  input logic     clk,
  input logic     reset_n,
  pc_unit_if.slave bus
);

  localparam logic [1:0] SrcInc = 2'b00;
  localparam logic [1:0] SrcRel = 2'b01;
  localparam logic [1:0] SrcAbs = 2'b10;
  localparam logic [1:0] SrcRet = 2'b11;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pc_sel;

  assign pc_inc = pc_q + WIDTH'(1);

  // Non-return candidates. Immediate is already WIDTH bits, so a plain add
  // modulo 2^WIDTH is the sign-extended relative branch.
  always_comb begin
    pc_sel = pc_inc;
    case (bus.pc_src)
      SrcInc:  pc_sel = pc_inc;
      SrcRel:  pc_sel = pc_q + bus.immediate;
      SrcAbs:  pc_sel = bus.immediate;
      SrcRet:  pc_sel = pc_inc;
      default: pc_sel = pc_inc;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= RESET_ADDR;
    end else if (!bus.stall) begin
      pc_q <= pc_d;
    end
  end

  assign bus.pc = pc_q;

`ifdef PC_RAS_EN

  localparam int unsigned PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);
  localparam logic [CntW-1:0] DepthMax = CntW'(RAS_DEPTH);

  // Entries are not reset; depth alone decides which are valid.
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  // sp_q points at the next free slot. When full it wraps onto the oldest
  // entry, so a push there overwrites it for free.
  logic [PtrW-1:0] sp_q, sp_d;
  logic [CntW-1:0] depth_q, depth_d;
  logic            err_q, err_d;

  logic [PtrW-1:0]  top_idx;
  logic [WIDTH-1:0] top_val;
  logic             do_push, do_pop;
  logic             ras_we;
  logic [PtrW-1:0]  ras_widx;
  logic             is_empty;

  assign top_idx  = sp_q - PtrW'(1);
  assign top_val  = ras_q[top_idx];
  assign do_push  = bus.call;
  assign do_pop   = (bus.pc_src == SrcRet);
  assign is_empty = (depth_q == '0);

  always_comb begin
    pc_d     = pc_sel;
    sp_d     = sp_q;
    depth_d  = depth_q;
    err_d    = err_q;
    ras_we   = 1'b0;
    ras_widx = sp_q;

    if (do_push && do_pop) begin
      // Return to the current top and replace it with the new return
      // address in place; depth and error state are untouched.
      if (!is_empty) begin
        pc_d     = top_val;
        ras_we   = 1'b1;
        ras_widx = top_idx;
      end else begin
        pc_d = pc_inc;
      end
    end else if (do_pop) begin
      if (is_empty) begin
        pc_d  = pc_inc;
        err_d = 1'b1;
      end else begin
        pc_d    = top_val;
        sp_d    = top_idx;
        depth_d = depth_q - CntW'(1);
      end
    end else if (do_push) begin
      ras_we   = 1'b1;
      ras_widx = sp_q;
      sp_d     = sp_q + PtrW'(1);
      if (depth_q == DepthMax) begin
        err_d = 1'b1;
      end else begin
        depth_d = depth_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp_q    <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else if (!bus.stall) begin
      sp_q    <= sp_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!bus.stall && ras_we) begin
      ras_q[ras_widx] <= pc_inc;
    end
  end

  assign bus.ras_empty = is_empty;
  assign bus.ras_full  = (depth_q == DepthMax);
  assign bus.ras_err   = err_q;

`else

  // No stack: return decays to increment (pc_sel already does that).
  assign pc_d = pc_sel;

  logic unused_call;
  assign unused_call = bus.call;

  assign bus.ras_empty = 1'b1;
  assign bus.ras_full  = 1'b0;
  assign bus.ras_err   = 1'b0;

`endif

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit (WIDTH=8, RAS_DEPTH=4, RESET_ADDR=0). Covers both the
// default build and a PC_RAS_EN build; expectations are hand-derived.
module tb_pc_unit;

  logic clk;
  logic reset_n;

  pc_unit_if #(.WIDTH(8)) bus ();

  pc_unit #(
    .WIDTH     (8),
    .RAS_DEPTH (4),
    .RESET_ADDR(8'h00)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       stall;
    logic [1:0] src;
    logic       call;
    logic [7:0] imm;
    logic [7:0] exp_pc;
    logic       exp_empty;
    logic       exp_full;
    logic       exp_err;
  } vec_t;

  typedef struct {
    logic [7:0] pc;
    logic       empty;
    logic       full;
    logic       err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp;
  int   n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, ".pc"},        {24'h0, bus.pc},    {24'h0, e.pc});
    check({tag, ".ras_empty"}, {31'h0, bus.ras_empty}, {31'h0, e.empty});
    check({tag, ".ras_full"},  {31'h0, bus.ras_full},  {31'h0, e.full});
    check({tag, ".ras_err"},   {31'h0, bus.ras_err},   {31'h0, e.err});
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(input string tag, input vec_t v);
    exp_t e;
    bus.stall     = v.stall;
    bus.pc_src    = v.src;
    bus.call      = v.call;
    bus.immediate = v.imm;
    e.pc    = v.exp_pc;
    e.empty = v.exp_empty;
    e.full  = v.exp_full;
    e.err   = v.exp_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      check_outputs(tag, sb.pop_front());
    end
  endtask

  function automatic vec_t mk(input logic st, input logic [1:0] src, input logic cl,
                              input logic [7:0] imm, input logic [7:0] pc,
                              input logic em, input logic fu, input logic er);
    vec_t v;
    v.stall = st; v.src = src; v.call = cl; v.imm = imm;
    v.exp_pc = pc; v.exp_empty = em; v.exp_full = fu; v.exp_err = er;
    return v;
  endfunction

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t rst_e;
    n_cmp = 0;
    n_bad = 0;
    rst_e.pc = 8'h00; rst_e.empty = 1'b1; rst_e.full = 1'b0; rst_e.err = 1'b0;

    // stall, src, call, imm -> pc, empty, full, err
    // Branch and wrap
    vecs.push_back(mk(0, 2'b10, 0, 8'h05, 8'h05, 1, 0, 0));
    vecs.push_back(mk(0, 2'b01, 0, 8'hFD, 8'h02, 1, 0, 0));
    vecs.push_back(mk(0, 2'b10, 0, 8'hFE, 8'hFE, 1, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 8'h00, 8'hFF, 1, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 8'h00, 8'h00, 1, 0, 0));
    vecs.push_back(mk(0, 2'b01, 0, 8'hFF, 8'hFF, 1, 0, 0));
    vecs.push_back(mk(0, 2'b01, 0, 8'h01, 8'h00, 1, 0, 0));
    // Jump and stall
    vecs.push_back(mk(0, 2'b10, 0, 8'h40, 8'h40, 1, 0, 0));
    vecs.push_back(mk(1, 2'b01, 0, 8'h05, 8'h40, 1, 0, 0));
    vecs.push_back(mk(1, 2'b01, 0, 8'h05, 8'h40, 1, 0, 0));
    vecs.push_back(mk(1, 2'b01, 0, 8'h05, 8'h40, 1, 0, 0));
    vecs.push_back(mk(0, 2'b00, 0, 8'h00, 8'h41, 1, 0, 0));
`ifdef PC_RAS_EN
    // Call / return
    vecs.push_back(mk(0, 2'b10, 0, 8'h10, 8'h10, 1, 0, 0));
    vecs.push_back(mk(0, 2'b10, 1, 8'h80, 8'h80, 0, 0, 0));
    vecs.push_back(mk(0, 2'b10, 1, 8'hA0, 8'hA0, 0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 0, 8'h00, 8'h81, 0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 0, 8'h00, 8'h11, 1, 0, 0));
    // Call+return in one cycle replaces the top
    vecs.push_back(mk(0, 2'b10, 1, 8'h30, 8'h30, 0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 1, 8'h00, 8'h12, 0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 0, 8'h00, 8'h31, 1, 0, 0));
    // Stall ignores call and return
    vecs.push_back(mk(0, 2'b10, 1, 8'h50, 8'h50, 0, 0, 0));
    vecs.push_back(mk(1, 2'b11, 1, 8'h00, 8'h50, 0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 0, 8'h00, 8'h32, 1, 0, 0));
    // Overflow: fifth push overwrites return address 33
    vecs.push_back(mk(0, 2'b10, 1, 8'h60, 8'h60, 0, 0, 0));
    vecs.push_back(mk(0, 2'b10, 1, 8'h70, 8'h70, 0, 0, 0));
    vecs.push_back(mk(0, 2'b10, 1, 8'h80, 8'h80, 0, 0, 0));
    vecs.push_back(mk(0, 2'b10, 1, 8'h90, 8'h90, 0, 1, 0));
    vecs.push_back(mk(0, 2'b10, 1, 8'hA0, 8'hA0, 0, 1, 1));
    // LIFO drain then underflow
    vecs.push_back(mk(0, 2'b11, 0, 8'h00, 8'h91, 0, 0, 1));
    vecs.push_back(mk(0, 2'b11, 0, 8'h00, 8'h81, 0, 0, 1));
    vecs.push_back(mk(0, 2'b11, 0, 8'h00, 8'h71, 0, 0, 1));
    vecs.push_back(mk(0, 2'b11, 0, 8'h00, 8'h61, 1, 0, 1));
    vecs.push_back(mk(0, 2'b11, 0, 8'h00, 8'h62, 1, 0, 1));
    vecs.push_back(mk(0, 2'b00, 0, 8'h00, 8'h63, 1, 0, 1));
`else
    // No RAS: call ignored, return acts as increment
    vecs.push_back(mk(0, 2'b10, 0, 8'h07, 8'h07, 1, 0, 0));
    vecs.push_back(mk(0, 2'b11, 1, 8'h00, 8'h08, 1, 0, 0));
    vecs.push_back(mk(0, 2'b11, 0, 8'h00, 8'h09, 1, 0, 0));
    vecs.push_back(mk(0, 2'b10, 1, 8'h20, 8'h20, 1, 0, 0));
    vecs.push_back(mk(0, 2'b11, 0, 8'h55, 8'h21, 1, 0, 0));
`endif

    bus.stall     = 1'b0;
    bus.pc_src    = 2'b00;
    bus.call      = 1'b0;
    bus.immediate = 8'h00;
    reset_n       = 1'b0;

    // Reset holds across edges
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", rst_e);

    // Release between edges, then increment 1,2,3
    reset_n = 1'b1;
    step("inc1", mk(0, 2'b00, 0, 8'h00, 8'h01, 1, 0, 0));
    step("inc2", mk(0, 2'b00, 0, 8'h00, 8'h02, 1, 0, 0));
    step("inc3", mk(0, 2'b00, 0, 8'h00, 8'h03, 1, 0, 0));

    // Asynchronous reset mid-cycle
    #2;
    reset_n = 1'b0;
    #1;
    check_outputs("async_reset", rst_e);
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i]);
    end

    // Sticky error (if any) clears only on reset
    #2;
    reset_n = 1'b0;
    #1;
    check_outputs("final_reset", rst_e);
    #1;
    reset_n = 1'b1;
    step("post_reset_inc", mk(0, 2'b00, 0, 8'h00, 8'h01, 1, 0, 0));

    check("scoreboard_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
